// File: rtl/tx_frame_pkg.sv
// Shared types and constants for the 12-bit TX frame generator: FSM states,
// sync header / code words, blanking word and the PRBS-12 generator.
package tx_frame_pkg;

  typedef enum logic [2:0] {
    ST_TRAIN,
    ST_SAV,
    ST_ACTIVE,
    ST_EAV,
    ST_HBLANK
  } state_t;

  localparam logic [11:0] SYNC_ONES  = 12'hFFF;
  localparam logic [11:0] SYNC_ZERO  = 12'h000;
  localparam logic [11:0] SAV_ACT    = 12'h800;
  localparam logic [11:0] EAV_ACT    = 12'h9D0;
  localparam logic [11:0] SAV_BLK    = 12'hAB0;
  localparam logic [11:0] EAV_BLK    = 12'hB60;
  localparam logic [11:0] BLANK_WORD = 12'h040;

  // x^12 + x^6 + x^4 + x + 1, Fibonacci form shifting left: taps at bits 11,5,3,0.
  localparam logic [11:0] PRBS_TAPS = 12'h829;
  localparam logic [11:0] PRBS_SEED = 12'hFFF;

  function automatic logic [11:0] prbs12_next(input logic [11:0] s);
    return {s[10:0], ^(s & PRBS_TAPS)};
  endfunction

endpackage

// File: rtl/tx_frame_cnt.sv
// Word-within-state and line-within-phase counters with terminal-count flags.
module tx_frame_cnt
  import tx_frame_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             word_clr,
  input  logic             word_inc,
  input  logic [CNT_W-1:0] word_tc,
  input  logic             line_clr,
  input  logic             line_inc,
  input  logic [CNT_W-1:0] line_tc,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] line_cnt,
  output logic             word_last,
  output logic             line_last
);

  logic [CNT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] line_q, line_d;

  always_comb begin
    word_d = word_q;
    line_d = line_q;
    if (word_clr)      word_d = '0;
    else if (word_inc) word_d = word_q + CNT_W'(1);
    if (line_clr)      line_d = '0;
    else if (line_inc) line_d = line_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      line_q <= '0;
    end else begin
      word_q <= word_d;
      line_q <= line_d;
    end
  end

  assign word_cnt  = word_q;
  assign line_cnt  = line_q;
  assign word_last = (word_q == word_tc);
  assign line_last = (line_q == line_tc);

endmodule

// File: rtl/tx_frame_gen_12b.sv
// Video-style TX frame generator feeding a 12-bit serializer.
// Optional TX_PRBS_EN replaces active pixels with a PRBS-12 test pattern.
module tx_frame_gen_12b
  import tx_frame_pkg::*;
#(
  parameter int                DATA_W     = 12,
  parameter logic [DATA_W-1:0] TRAIN_WORD = 12'h3A6,
  parameter int                CNT_W      = 16
) (
  input  logic              px_clk,
  input  logic              px_reset_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  cfg_hact,
  input  logic [CNT_W-1:0]  cfg_hblank,
  input  logic [CNT_W-1:0]  cfg_vact,
  input  logic [CNT_W-1:0]  cfg_vblank,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_frame_start,
  output logic              tx_busy,
  output logic              underflow,
  input  logic              underflow_clr
);

  state_t state_q, state_d;
  logic   blank_q, blank_d;
  logic [CNT_W-1:0] hact_q, hact_d, hblank_q, hblank_d;
  logic [CNT_W-1:0] vact_q, vact_d, vblank_q, vblank_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic frame_start_q, frame_start_d;
  logic busy_q, busy_d;
  logic underflow_q, underflow_d;

  logic             word_clr, word_inc, line_clr, line_inc;
  logic [CNT_W-1:0] word_tc, line_tc, word_cnt, line_cnt;
  logic             word_last, line_last;
  logic             eol, last_line, frame_end, start_frame, active_px;
  logic [DATA_W-1:0] px_word;
  logic             uf_set;

  tx_frame_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk       (px_clk),
    .rst_n     (px_reset_n),
    .word_clr  (word_clr),
    .word_inc  (word_inc),
    .word_tc   (word_tc),
    .line_clr  (line_clr),
    .line_inc  (line_inc),
    .line_tc   (line_tc),
    .word_cnt  (word_cnt),
    .line_cnt  (line_cnt),
    .word_last (word_last),
    .line_last (line_last)
  );

  // A line ends after its last HBLANK word, or after EAV when HBLANK is skipped.
  assign eol = ((state_q == ST_EAV) && word_last && (hblank_q == '0)) ||
               ((state_q == ST_HBLANK) && word_last);
  assign last_line   = blank_q ? line_last : (line_last && (vblank_q == '0));
  assign frame_end   = eol && last_line;
  assign start_frame = ((state_q == ST_TRAIN) || frame_end) && enable;
  assign active_px   = (state_q == ST_ACTIVE) && !blank_q;
  assign line_tc     = blank_q ? (vblank_q - CNT_W'(1)) : (vact_q - CNT_W'(1));

  always_comb begin
    word_tc = '0;
    case (state_q)
      ST_SAV, ST_EAV: word_tc = CNT_W'(3);
      ST_ACTIVE:      word_tc = hact_q - CNT_W'(1);
      ST_HBLANK:      word_tc = hblank_q - CNT_W'(1);
      default:        word_tc = '0;
    endcase
  end

`ifdef TX_PRBS_EN
  logic [11:0] prbs_q, prbs_d;
  logic        unused_pix;

  always_comb begin
    prbs_d = prbs_q;
    if (start_frame)    prbs_d = PRBS_SEED;
    else if (active_px) prbs_d = prbs12_next(prbs_q);
  end

  always_ff @(posedge px_clk or negedge px_reset_n) begin
    if (!px_reset_n) prbs_q <= PRBS_SEED;
    else             prbs_q <= prbs_d;
  end

  assign unused_pix = ^{pix_data, pix_valid};
  assign pix_ready  = 1'b0;
  assign px_word    = DATA_W'(prbs_q);
  assign uf_set     = 1'b0;
`else
  assign pix_ready  = active_px;
  assign px_word    = pix_valid ? pix_data : '0;
  assign uf_set     = active_px && !pix_valid;
`endif

  always_comb begin
    state_d       = state_q;
    blank_d       = blank_q;
    hact_d        = hact_q;
    hblank_d      = hblank_q;
    vact_d        = vact_q;
    vblank_d      = vblank_q;
    word_clr      = (state_q == ST_TRAIN) || word_last;
    word_inc      = !word_clr;
    line_clr      = 1'b0;
    line_inc      = 1'b0;
    tx_data_d     = TRAIN_WORD;
    frame_start_d = 1'b0;
    busy_d        = (state_q != ST_TRAIN);
    underflow_d   = uf_set || (underflow_q && !underflow_clr);

    case (state_q)
      ST_TRAIN: begin
        line_clr = 1'b1;
        blank_d  = 1'b0;
        if (enable) state_d = ST_SAV;
      end
      ST_SAV: begin
        if (word_last) state_d = ST_ACTIVE;
        if (word_cnt == '0) tx_data_d = DATA_W'(SYNC_ONES);
        else if (word_cnt == CNT_W'(3)) tx_data_d = DATA_W'(blank_q ? SAV_BLK : SAV_ACT);
        else tx_data_d = DATA_W'(SYNC_ZERO);
        frame_start_d = (word_cnt == '0) && (line_cnt == '0) && !blank_q;
      end
      ST_ACTIVE: begin
        if (word_last) state_d = ST_EAV;
        tx_data_d = blank_q ? DATA_W'(BLANK_WORD) : px_word;
      end
      ST_EAV: begin
        if (word_last && (hblank_q != '0)) state_d = ST_HBLANK;
        if (word_cnt == '0) tx_data_d = DATA_W'(SYNC_ONES);
        else if (word_cnt == CNT_W'(3)) tx_data_d = DATA_W'(blank_q ? EAV_BLK : EAV_ACT);
        else tx_data_d = DATA_W'(SYNC_ZERO);
      end
      ST_HBLANK: tx_data_d = DATA_W'(BLANK_WORD);
      default:   state_d = ST_TRAIN;
    endcase

    if (eol) begin
      if (frame_end) begin
        line_clr = 1'b1;
        blank_d  = 1'b0;
        state_d  = enable ? ST_SAV : ST_TRAIN;
      end else begin
        state_d = ST_SAV;
        if (!blank_q && line_last) begin
          blank_d  = 1'b1;
          line_clr = 1'b1;
        end else begin
          line_inc = 1'b1;
        end
      end
    end

    // Geometry is frozen per frame; zero active sizes are clamped to one.
    if (start_frame) begin
      hact_d   = (cfg_hact == '0) ? CNT_W'(1) : cfg_hact;
      vact_d   = (cfg_vact == '0) ? CNT_W'(1) : cfg_vact;
      hblank_d = cfg_hblank;
      vblank_d = cfg_vblank;
    end
  end

  always_ff @(posedge px_clk or negedge px_reset_n) begin
    if (!px_reset_n) begin
      state_q       <= ST_TRAIN;
      blank_q       <= 1'b0;
      hact_q        <= CNT_W'(1);
      hblank_q      <= '0;
      vact_q        <= CNT_W'(1);
      vblank_q      <= '0;
      tx_data_q     <= TRAIN_WORD;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      blank_q       <= blank_d;
      hact_q        <= hact_d;
      hblank_q      <= hblank_d;
      vact_q        <= vact_d;
      vblank_q      <= vblank_d;
      tx_data_q     <= tx_data_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      underflow_q   <= underflow_d;
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_frame_start = frame_start_q;
  assign tx_busy        = busy_q;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_tx_frame_gen_12b.sv
// Directed self-checking bench for tx_frame_gen_12b (honours TX_PRBS_EN if defined).
module tb_tx_frame_gen_12b;

  localparam int DW = 12;
  localparam int CW = 16;
`ifdef TX_PRBS_EN
  localparam bit PRBS = 1'b1;
`else
  localparam bit PRBS = 1'b0;
`endif

  logic          px_clk = 1'b0;
  logic          px_reset_n;
  logic          enable;
  logic [CW-1:0] cfg_hact, cfg_hblank, cfg_vact, cfg_vblank;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] tx_data;
  logic          tx_frame_start;
  logic          tx_busy;
  logic          underflow;
  logic          underflow_clr;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_pix;
  logic [11:0] prbs_m;

  always #5 px_clk = ~px_clk;

  tx_frame_gen_12b dut (
    .px_clk         (px_clk),
    .px_reset_n     (px_reset_n),
    .enable         (enable),
    .cfg_hact       (cfg_hact),
    .cfg_hblank     (cfg_hblank),
    .cfg_vact       (cfg_vact),
    .cfg_vblank     (cfg_vblank),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .tx_data        (tx_data),
    .tx_frame_start (tx_frame_start),
    .tx_busy        (tx_busy),
    .underflow      (underflow),
    .underflow_clr  (underflow_clr)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] prbs_step(input logic [11:0] s);
    return {s[10:0], s[11] ^ s[5] ^ s[3] ^ s[0]};
  endfunction

  // Advance one cycle; the upstream source moves to its next pixel on a handshake.
  task automatic tick();
    logic acc;
    acc = pix_ready & pix_valid;
    @(negedge px_clk);
    if (acc) pix_data = pix_data + 12'd1;
  endtask

  task automatic check_line(input string tag, input int hact, input int hblank,
                            input bit blank, input bit first, input int drop,
                            input bit clr_on_drop, input int en_off);
    int          len;
    logic [11:0] exp_w;
    bit          rdy_exp;
    len = 8 + hact + hblank;
    if (first) prbs_m = 12'hFFF;
    for (int i = 0; i < len; i++) begin
      if (drop >= 0 && i == 4 + drop) begin
        pix_valid     = 1'b0;
        underflow_clr = clr_on_drop;
      end
      tick();
      pix_valid     = 1'b1;
      underflow_clr = 1'b0;
      if (i == en_off) enable = 1'b0;
      if (i < 4) begin
        exp_w = (i == 0) ? 12'hFFF : (i == 3) ? (blank ? 12'hAB0 : 12'h800) : 12'h000;
      end else if (i < 4 + hact) begin
        if (blank) exp_w = 12'h040;
        else if (PRBS) begin
          exp_w  = prbs_m;
          prbs_m = prbs_step(prbs_m);
        end else if (i == 4 + drop) exp_w = 12'h000;
        else begin
          exp_w   = exp_pix;
          exp_pix = exp_pix + 12'd1;
        end
      end else if (i < 8 + hact) begin
        exp_w = (i == 4 + hact) ? 12'hFFF :
                (i == 7 + hact) ? (blank ? 12'hB60 : 12'h9D0) : 12'h000;
      end else begin
        exp_w = 12'h040;
      end
      rdy_exp = !PRBS && !blank && (i + 1 >= 4) && (i + 1 < 4 + hact);
      chk($sformatf("%s_w%0d_data", tag, i), tx_data, exp_w);
      chk($sformatf("%s_w%0d_fstart", tag, i), tx_frame_start, first && (i == 0));
      chk($sformatf("%s_w%0d_busy", tag, i), tx_busy, 1'b1);
      chk($sformatf("%s_w%0d_ready", tag, i), pix_ready, rdy_exp);
    end
    $display("line %s hact=%0d hblank=%0d blank=%0d words=%0d", tag, hact, hblank, blank, len);
  endtask

  initial begin
    px_reset_n    = 1'b0;
    enable        = 1'b0;
    cfg_hact      = 16'd4;
    cfg_hblank    = 16'd2;
    cfg_vact      = 16'd2;
    cfg_vblank    = 16'd1;
    pix_data      = 12'h101;
    pix_valid     = 1'b1;
    underflow_clr = 1'b0;
    exp_pix       = 12'h101;
    prbs_m        = 12'hFFF;

    repeat (3) @(negedge px_clk);
    chk("rst_data", tx_data, 12'h3A6);
    chk("rst_ready", pix_ready, 1'b0);
    chk("rst_fstart", tx_frame_start, 1'b0);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_uf", underflow, 1'b0);
    px_reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      tick();
      chk("idle_data", tx_data, 12'h3A6);
      chk("idle_ready", pix_ready, 1'b0);
      chk("idle_busy", tx_busy, 1'b0);
    end
    $display("idle training checked");

    // Frame A, then frame B back to back with one starved pixel and enable dropped early.
    enable = 1'b1;
    tick();
    chk("A_pre_data", tx_data, 12'h3A6);
    check_line("A0", 4, 2, 1'b0, 1'b1, -1, 1'b0, -1);
    check_line("A1", 4, 2, 1'b0, 1'b0, -1, 1'b0, -1);
    check_line("A2", 4, 2, 1'b1, 1'b0, -1, 1'b0, -1);
    chk("A_uf", underflow, 1'b0);
    check_line("B0", 4, 2, 1'b0, 1'b1, 1, 1'b0, 5);
    chk("B0_uf", underflow, !PRBS);
    cfg_hact = 16'd3;
    check_line("B1", 4, 2, 1'b0, 1'b0, -1, 1'b0, -1);
    check_line("B2", 4, 2, 1'b1, 1'b0, -1, 1'b0, -1);
    tick();
    chk("B_end_data", tx_data, 12'h3A6);
    chk("B_end_busy", tx_busy, 1'b0);
    chk("B_end_uf", underflow, !PRBS);
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    chk("uf_clr", underflow, 1'b0);

    // Frame C picks up hact=3; clear and new underflow collide, then reset mid-ACTIVE.
    enable = 1'b1;
    tick();
    chk("C_pre_data", tx_data, 12'h3A6);
    check_line("C0", 3, 2, 1'b0, 1'b1, 0, 1'b1, -1);
    chk("C0_uf_hold", underflow, !PRBS);
    repeat (4) tick();
    chk("C1_active_ready", pix_ready, !PRBS);
    px_reset_n = 1'b0;
    #1;
    chk("midrst_data", tx_data, 12'h3A6);
    chk("midrst_ready", pix_ready, 1'b0);
    chk("midrst_fstart", tx_frame_start, 1'b0);
    chk("midrst_busy", tx_busy, 1'b0);
    chk("midrst_uf", underflow, 1'b0);
    @(negedge px_clk);
    chk("midrst_hold_data", tx_data, 12'h3A6);
    px_reset_n = 1'b1;
    $display("reset mid-frame checked");

    tick();
    chk("D_pre_data", tx_data, 12'h3A6);
    check_line("D0", 3, 2, 1'b0, 1'b1, -1, 1'b0, 2);
    check_line("D1", 3, 2, 1'b0, 1'b0, -1, 1'b0, -1);
    check_line("D2", 3, 2, 1'b1, 1'b0, -1, 1'b0, -1);
    tick();
    chk("D_end_data", tx_data, 12'h3A6);
    chk("D_end_busy", tx_busy, 1'b0);

    // All-zero geometry: clamps to a single one-pixel line with no blanking.
    cfg_hact   = 16'd0;
    cfg_hblank = 16'd0;
    cfg_vact   = 16'd0;
    cfg_vblank = 16'd0;
    enable     = 1'b1;
    tick();
    chk("E_pre_data", tx_data, 12'h3A6);
    enable = 1'b0;
    check_line("E0", 1, 0, 1'b0, 1'b1, -1, 1'b0, -1);
    tick();
    chk("E_end_data", tx_data, 12'h3A6);
    chk("E_end_busy", tx_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_gen_12b.md
TX_FRAME_GEN_12B -- requirements
Module: tx_frame_gen_12b

Interface
REQ-001 SHALL have parameter DATA_W, default 12, serial word width fed to downstream OSERDES.
REQ-002 SHALL have parameter TRAIN_WORD, default 12'h3A6, word sent while idle/training.
REQ-003 SHALL have parameter CNT_W, default 16, width of all line/pixel counters and cfg inputs.
REQ-004 SHALL have ports, in order:
  px_clk  in  1  single clock, pixel-word rate.
  px_reset_n  in  1  asynchronous active-low reset.
  enable  in  1  start/stop frame transmission.
  cfg_hact / cfg_hblank  in  CNT_W each  active words per line / blanking words per line.
  cfg_vact / cfg_vblank  in  CNT_W each  active lines / blanking lines per frame.
  pix_data  in  DATA_W  upstream pixel.
  pix_valid  in  1  upstream pixel valid.
  pix_ready  out  1  pixel accepted when pix_valid & pix_ready.
  tx_data  out  DATA_W  registered word to serializer.
  tx_frame_start  out  1  one-cycle pulse with first SAV word of a frame.
  tx_busy  out  1  high from frame start to end of last vblank line.
  underflow  out  1  sticky: ACTIVE word needed and pix_valid low.
  underflow_clr  in  1  clears underflow.

Function
REQ-005 SHALL implement FSM states TRAIN, SAV, ACTIVE, EAV, HBLANK.
REQ-006 TRAIN SHALL output TRAIN_WORD every cycle; leave to SAV only when enable=1.
REQ-007 SAV and EAV SHALL each emit 4 words: 12'hFFF, 12'h000, 12'h000, code.
REQ-008 Codes: SAV active 12'h800, EAV active 12'h9D0, SAV blank 12'hAB0, EAV blank 12'hB60.
REQ-009 ACTIVE SHALL emit cfg_hact words; HBLANK SHALL emit cfg_hblank words of 12'h040.
REQ-010 Active lines (first cfg_vact) SHALL carry pixels in ACTIVE; blank lines (next cfg_vblank) SHALL carry 12'h040 in ACTIVE and use blank codes.
REQ-011 pix_ready SHALL equal (state==ACTIVE & active line); combinational from state register only.
REQ-012 ACTIVE word with pix_valid=0 SHALL output 12'h000, set underflow; line length unchanged.
REQ-013 tx_data SHALL lag state/pixel acceptance by exactly 1 px_clk.
REQ-014 cfg_* SHALL be sampled at frame start (TRAIN->SAV or last HBLANK of frame); mid-frame changes ignored.
REQ-015 Sampled cfg value 0 SHALL be clamped to 1 (cfg_hblank, cfg_vblank: 0 allowed, state skipped).
REQ-016 After last HBLANK of frame: enable=1 -> SAV of next frame, no gap; enable=0 -> TRAIN.
REQ-017 enable deassert mid-frame SHALL NOT truncate; frame completes first.
REQ-018 underflow_clr and new underflow in same cycle: underflow SHALL stay 1.
REQ-019 Counters SHALL not wrap within a line; terminal compare is count==cfg-1.

Reset
REQ-020 On px_reset_n low: state TRAIN, tx_data=TRAIN_WORD, pix_ready=0, tx_frame_start=0, tx_busy=0, underflow=0, counters 0.
REQ-021 Reset mid-frame SHALL abort immediately; first frame after release starts with SAV line 0.

Configuration
REQ-022 Macro TX_PRBS_EN: when defined, active-line ACTIVE words SHALL be PRBS-12 (x^12+x^6+x^4+x+1, seed 12'hFFF at each frame start), pix_ready=0, underflow never sets; when undefined, pixels from pix_data per REQ-010..012.

Structure
REQ-023 Package tx_frame_pkg SHALL hold state enum, sync header/code constants, blank word 12'h040, PRBS polynomial/seed.
REQ-024 SHALL instantiate one sub-module tx_frame_cnt (line/word counter with terminal flags); PRBS inline.

Verification
REQ-025 Reset, enable=0 -> tx_data=12'h3A6 continuously, pix_ready=0.
REQ-026 hact=4,hblank=2,vact=2,vblank=1, pix_valid=1 -> per line FFF,000,000,800,4 px,FFF,000,000,9D0,040,040; blank line uses AB0/B60; tx_frame_start once per frame.
REQ-027 pix_valid low for 1 cycle in ACTIVE -> one 12'h000 word, underflow=1, line still 4 pixels long; underflow_clr -> 0.
REQ-028 enable dropped during line 0 -> full frame completes, then TRAIN_WORD; cfg_hact changed mid-frame -> applied next frame only.
REQ-029 px_reset_n pulsed mid-ACTIVE -> next cycle tx_data=12'h3A6, all outputs at reset values.
REQ-030 TX_PRBS_EN defined -> ACTIVE words match reference PRBS-12 from seed 12'hFFF, pix_ready=0 throughout.
